// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: port IDs and the per-port request bundle.
package mem_arb_pkg;

    localparam int PORT_COUNT = 2;

    typedef logic port_id_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of granted port IDs; zero-latency head, push refused when full unless a pop frees a slot.
// Backpressure: the caller must gate its requests on full/count.
module arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  port_id_t                   push_dat,
    input  logic                       pop,
    output port_id_t                   head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    port_id_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= wrap_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= wrap_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin merge of two req/gnt/rvalid ports onto one memory port; 0-cycle request path, responses routed in order.
// Backpressure: requestors stall on missing mem_gnt_i or when MAX_OUTSTANDING responses are pending.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit RESET_PRIORITY  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  s_req_i,
    input  logic [1:0]  s_we_i,
    input  logic [63:0] s_addr_i,
    input  logic [63:0] s_wdata_i,
    input  logic [7:0]  s_be_i,
    output logic [1:0]  s_gnt_o,
    output logic [1:0]  s_rvalid_o,
    output logic [31:0] s_rdata_o,
    output logic [1:0]  s_error_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_error_i,
    output logic        spurious_rvalid_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    mem_req_t       port_req [PORT_COUNT];
    mem_req_t       mem_fields;
    port_id_t       sel;
    port_id_t       last_q;
    port_id_t       lock_id_q;
    logic           lock_vld_q;
    logic           spurious_q;
    logic           hs;
    logic           resp;
    port_id_t       head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;

    always_comb begin
        for (int p = 0; p < PORT_COUNT; p++) begin
            port_req[p] = '{we:    s_we_i[p],
                            be:    s_be_i[4*p +: 4],
                            addr:  s_addr_i[32*p +: 32],
                            wdata: s_wdata_i[32*p +: 32]};
        end
    end

    // A stalled request keeps its port until granted so memory sees stable fields.
    always_comb begin
        if (lock_vld_q && s_req_i[lock_id_q]) begin
            sel = lock_id_q;
        end else if (&s_req_i) begin
            sel = ~last_q;
        end else begin
            sel = s_req_i[1];
        end
    end

    assign mem_req_o   = rst_n & s_req_i[sel] & (fifo_count < CW'(MAX_OUTSTANDING));
    assign mem_fields  = mem_req_o ? port_req[sel] : '0;
    assign mem_we_o    = mem_fields.we;
    assign mem_be_o    = mem_fields.be;
    assign mem_addr_o  = mem_fields.addr;
    assign mem_wdata_o = mem_fields.wdata;
    assign hs          = mem_req_o & mem_gnt_i;
    assign resp        = mem_rvalid_i & ~fifo_empty;
    assign s_rdata_o   = resp ? mem_rdata_i : '0;
    assign spurious_rvalid_o = spurious_q;

    always_comb begin
        s_gnt_o          = '0;
        s_rvalid_o       = '0;
        s_error_o        = '0;
        s_gnt_o[sel]     = hs;
        s_rvalid_o[head] = resp;
        s_error_o[head]  = resp & mem_error_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q     <= port_id_t'(!RESET_PRIORITY);
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
            spurious_q <= 1'b0;
        end else begin
            lock_vld_q <= mem_req_o & ~mem_gnt_i;
            if (mem_req_o) begin
                lock_id_q <= sel;
            end
            if (hs) begin
                last_q <= sel;
            end
            if (mem_rvalid_i && fifo_empty) begin
                spurious_q <= 1'b1;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (hs),
        .push_dat (sel),
        .pop      (mem_rvalid_i),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    a_no_req_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full |-> !mem_req_o);
    a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a queue-based reference model checked every cycle.
module tb_mem_port_arbiter;
    localparam int MAXO = 2;

    logic        clk;
    logic        rst_n;
    logic [1:0]  s_req_i;
    logic [1:0]  s_we_i;
    logic [63:0] s_addr_i;
    logic [63:0] s_wdata_i;
    logic [7:0]  s_be_i;
    logic [1:0]  s_gnt_o;
    logic [1:0]  s_rvalid_o;
    logic [31:0] s_rdata_o;
    logic [1:0]  s_error_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_error_i;
    logic        spurious_rvalid_o;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .RESET_PRIORITY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req_i(s_req_i), .s_we_i(s_we_i), .s_addr_i(s_addr_i),
        .s_wdata_i(s_wdata_i), .s_be_i(s_be_i),
        .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
        .s_error_o(s_error_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_error_i(mem_error_i),
        .spurious_rvalid_o(spurious_rvalid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: outstanding transactions are a queue of port numbers.
    int  mq[$];
    int  m_last;
    int  m_lock;
    bit  m_spur;
    bit  m_ok = 1'b0;

    initial begin : model
        forever begin
            int          sel, cnt, head;
            bit          e_req, hs, rsp;
            logic [31:0] e_addr, e_wdata;
            logic [3:0]  e_be;
            logic        e_we;
            logic [1:0]  e_gnt, e_rv, e_err;
            logic [31:0] e_rdata;
            @(negedge clk);
            cnt = mq.size();
            if (m_lock >= 0 && s_req_i[m_lock]) sel = m_lock;
            else if (s_req_i == 2'b11)          sel = 1 - m_last;
            else if (s_req_i[1])                sel = 1;
            else                                sel = 0;
            e_req   = rst_n && s_req_i[sel] && (cnt < MAXO);
            e_addr  = e_req ? s_addr_i[32*sel +: 32]  : 32'h0;
            e_wdata = e_req ? s_wdata_i[32*sel +: 32] : 32'h0;
            e_be    = e_req ? s_be_i[4*sel +: 4]      : 4'h0;
            e_we    = e_req ? s_we_i[sel]             : 1'b0;
            hs      = e_req && mem_gnt_i;
            e_gnt   = hs ? 2'(1 << sel) : 2'b00;
            rsp     = mem_rvalid_i && (cnt > 0);
            head    = (cnt > 0) ? mq[0] : 0;
            e_rv    = rsp ? 2'(1 << head) : 2'b00;
            e_err   = (rsp && mem_error_i) ? 2'(1 << head) : 2'b00;
            e_rdata = rsp ? mem_rdata_i : 32'h0;
            if (m_ok) begin
                chk("m_req",   64'(mem_req_o),   64'(e_req));
                chk("m_addr",  64'(mem_addr_o),  64'(e_addr));
                chk("m_wdata", 64'(mem_wdata_o), 64'(e_wdata));
                chk("m_be",    64'(mem_be_o),    64'(e_be));
                chk("m_we",    64'(mem_we_o),    64'(e_we));
                chk("m_gnt",   64'(s_gnt_o),     64'(e_gnt));
                chk("m_rvalid",64'(s_rvalid_o),  64'(e_rv));
                chk("m_error", 64'(s_error_o),   64'(e_err));
                chk("m_rdata", 64'(s_rdata_o),   64'(e_rdata));
                chk("m_spur",  64'(spurious_rvalid_o), 64'(m_spur));
            end
            @(posedge clk);
            if (!rst_n) begin
                mq.delete();
                m_last = 1;
                m_lock = -1;
                m_spur = 1'b0;
                m_ok   = 1'b1;
            end else begin
                if (rsp) void'(mq.pop_front());
                if (mem_rvalid_i && cnt == 0) m_spur = 1'b1;
                if (hs) begin
                    mq.push_back(sel);
                    m_last = sel;
                    m_lock = -1;
                end else if (e_req) begin
                    m_lock = sel;
                end else begin
                    m_lock = -1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_req_i = 2'b00; s_we_i = 2'b00; s_be_i = 8'h00;
        s_addr_i = 64'h0; s_wdata_i = 64'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_error_i = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    logic [1:0] rr_exp [4];

    initial begin
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        idle();
        rst_n = 1'b0;
        cyc();
        @(negedge clk);
        chk("rst_mem_req", 64'(mem_req_o), 64'h0);
        chk("rst_gnt", 64'(s_gnt_o), 64'h0);
        chk("rst_spur", 64'(spurious_rvalid_o), 64'h0);
        cyc();
        rst_n = 1'b1;

        // Single read from port 0.
        s_req_i = 2'b01; s_addr_i[31:0] = 32'h0000_0010; s_be_i = 8'h0F; mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("rd_gnt", 64'(s_gnt_o), 64'h1);
        chk("rd_addr", 64'(mem_addr_o), 64'h10);
        cyc(); idle();
        cyc();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_rvalid", 64'(s_rvalid_o), 64'h1);
        chk("rd_rdata", 64'(s_rdata_o), 64'hDEADBEEF);
        cyc(); idle();

        // Round-robin conflict right after reset.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            s_req_i = (k < 4) ? 2'b11 : 2'b00;
            s_addr_i = {32'h2000 + 32'(k), 32'h1000 + 32'(k)};
            mem_gnt_i = 1'b1;
            mem_rvalid_i = (k > 0);
            mem_rdata_i = 32'h100 + 32'(k);
            @(negedge clk);
            if (k < 4) chk("rr_gnt", 64'(s_gnt_o), 64'(rr_exp[k]));
            if (k > 0) chk("rr_rvalid", 64'(s_rvalid_o), 64'(rr_exp[k-1]));
            cyc();
        end
        idle();
        cyc();

        // Lock: stalled port 1 keeps the bus while port 0 joins.
        s_req_i = 2'b10; s_addr_i[63:32] = 32'h100;
        @(negedge clk);
        chk("lk_addr0", 64'(mem_addr_o), 64'h100);
        cyc();
        s_req_i = 2'b11; s_addr_i[31:0] = 32'h40;
        @(negedge clk);
        chk("lk_addr1", 64'(mem_addr_o), 64'h100);
        chk("lk_nognt", 64'(s_gnt_o), 64'h0);
        cyc();
        @(negedge clk);
        chk("lk_addr2", 64'(mem_addr_o), 64'h100);
        cyc();
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("lk_gnt_p1", 64'(s_gnt_o), 64'h2);
        cyc();
        @(negedge clk);
        chk("lk_gnt_p0", 64'(s_gnt_o), 64'h1);
        chk("lk_addr_p0", 64'(mem_addr_o), 64'h40);
        cyc();

        // Full: two outstanding, port 0 keeps asking.
        s_req_i = 2'b01;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("full_noreq", 64'(mem_req_o), 64'h0);
            cyc();
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11;
        @(negedge clk);
        chk("full_pop_noreq", 64'(mem_req_o), 64'h0);
        chk("full_pop_rv", 64'(s_rvalid_o), 64'h2);
        cyc();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("full_rereq", 64'(mem_req_o), 64'h1);
        chk("full_regnt", 64'(s_gnt_o), 64'h1);
        cyc();
        idle();
        mem_rvalid_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("drain_rv", 64'(s_rvalid_o), 64'h1);
            cyc();
        end
        idle();
        cyc();

        // Write with error response on port 1.
        s_req_i = 2'b10; s_we_i = 2'b10; s_addr_i[63:32] = 32'h200;
        s_wdata_i[63:32] = 32'hCAFE0000; s_be_i = 8'h30; mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("wr_be", 64'(mem_be_o), 64'h3);
        chk("wr_wdata", 64'(mem_wdata_o), 64'hCAFE0000);
        chk("wr_we", 64'(mem_we_o), 64'h1);
        chk("wr_gnt", 64'(s_gnt_o), 64'h2);
        cyc(); idle();
        mem_rvalid_i = 1'b1; mem_error_i = 1'b1;
        @(negedge clk);
        chk("wr_err", 64'(s_error_o), 64'h2);
        chk("wr_rvalid", 64'(s_rvalid_o), 64'h2);
        cyc(); idle();

        // Reset with one in flight, then a late rvalid.
        s_req_i = 2'b01; mem_gnt_i = 1'b1;
        cyc(); idle();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
        @(negedge clk);
        chk("sp_rvalid", 64'(s_rvalid_o), 64'h0);
        chk("sp_before", 64'(spurious_rvalid_o), 64'h0);
        cyc(); idle();
        @(negedge clk);
        chk("sp_set", 64'(spurious_rvalid_o), 64'h1);
        cyc();
        @(negedge clk);
        chk("sp_sticky", 64'(spurious_rvalid_o), 64'h1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("sp_cleared", 64'(spurious_rvalid_o), 64'h0);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
